// File: rtl/mux_sel_pkg.sv
// ---------------------------------------------------------------------------
// mux_sel_pkg
// Shared definitions for the round-robin select arbiter that drives the
// 2-bit select of the downstream 4x1 mux.
//   NUM_CH  : number of requesters / mux inputs
//   SEL_W   : width of the mux select
//   state_t : arbiter FSM states
//   one_hot : select index -> one-hot grant vector
// ---------------------------------------------------------------------------
package mux_sel_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [NUM_CH-1:0] one_hot(input logic [SEL_W-1:0] sel);
    return NUM_CH'(1) << sel;
  endfunction

endpackage

// File: rtl/mux_sel_arbiter_if.sv
// ---------------------------------------------------------------------------
// mux_sel_arbiter_if
// Request/grant bundle between the requesters and the select arbiter.
//   req     : per-channel request, req[i] belongs to mux input i
//   done    : current owner releases the mux (level)
//   s       : registered mux select
//   gnt     : registered one-hot grant, zero when idle
//   busy    : a grant is active
//   expired : one-cycle pulse after a forced release
// master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface mux_sel_arbiter_if;
  import mux_sel_pkg::*;

  logic [NUM_CH-1:0] req;
  logic              done;
  logic [SEL_W-1:0]  s;
  logic [NUM_CH-1:0] gnt;
  logic              busy;
  logic              expired;

  modport master (
    output req, done,
    input  s, gnt, busy, expired
  );

  modport slave (
    input  req, done,
    output s, gnt, busy, expired
  );

endinterface

// File: rtl/mux_sel_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin scan: returns the first set request bit found
// scanning upward from (last+1) mod NUM_CH, wrapping around.
//   req  : request vector
//   last : index of the previously granted channel
//   pick : selected channel index (equals last when nothing is requested)
//   any  : at least one request bit is set
// ---------------------------------------------------------------------------
module rr_pick
  import mux_sel_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  last,
  output logic [SEL_W-1:0]  pick,
  output logic              any
);

  logic [SEL_W-1:0] w_idx;

  // Walk offsets from farthest to nearest so the nearest hit after `last`
  // is the one left standing; offset NUM_CH wraps back to `last` itself,
  // giving the previous owner the lowest priority.
  always_comb begin
    pick  = last;
    any   = 1'b0;
    w_idx = last;
    for (int k = NUM_CH; k >= 1; k--) begin
      w_idx = last + SEL_W'(k);
      if (req[w_idx]) begin
        pick = w_idx;
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_sel_arbiter.sv
// ---------------------------------------------------------------------------
// mux_sel_arbiter
// Round-robin owner selection for the shared 4x1 mux. One requester owns the
// mux at a time; each grant lasts between HOLD_CYCLES and MAX_CYCLES cycles
// and consecutive grants are separated by one dead (gnt=0) cycle.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mux_sel_arbiter_if.slave (req, done in; s, gnt, busy, expired out)
//
// state | meaning
// IDLE  | no owner; arbitrate among req, mux select held at last value
// GRANT | one owner; hold counter runs, watch for release / timeout
// ---------------------------------------------------------------------------
module mux_sel_arbiter
  import mux_sel_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int MAX_CYCLES  = 16
)(
  input  logic             clk,
  input  logic             rst_n,
  mux_sel_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] C_HOLD_TC = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_MAX_TC  = CNT_W'(MAX_CYCLES - 1);

  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("HOLD_CYCLES must be >= 1");
  end
  if (MAX_CYCLES < HOLD_CYCLES) begin : g_bad_max
    $error("MAX_CYCLES must be >= HOLD_CYCLES");
  end

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [SEL_W-1:0]  r_last;
  logic [SEL_W-1:0]  r_s;
  logic [NUM_CH-1:0] r_gnt;
  logic              r_busy;
  logic              r_expired;

  logic [SEL_W-1:0]  w_pick;
  logic              w_any;
  logic              w_min_met;
  logic              w_rel_norm;
  logic              w_rel_force;

  rr_pick u_rr_pick (
    .req  (bus.req),
    .last (r_last),
    .pick (w_pick),
    .any  (w_any)
  );

  // Release requests before the minimum hold are simply not looked at; done
  // is a level, so it must still be asserted when the minimum is reached.
  assign w_min_met   = (r_cnt >= C_HOLD_TC);
  assign w_rel_norm  = w_min_met && (bus.done || !bus.req[r_s]);
  assign w_rel_force = (r_cnt == C_MAX_TC) && !w_rel_norm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_last    <= SEL_W'(NUM_CH - 1);
      r_s       <= '0;
      r_gnt     <= '0;
      r_busy    <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_expired <= 1'b0;
          if (w_any) begin
            r_state <= GRANT;
            r_s     <= w_pick;
            r_gnt   <= one_hot(w_pick);
            r_busy  <= 1'b1;
            r_cnt   <= '0;
          end
        end
        GRANT: begin
          if (w_rel_norm || w_rel_force) begin
            r_state   <= IDLE;
            r_gnt     <= '0;
            r_busy    <= 1'b0;
            r_last    <= r_s;
            r_expired <= w_rel_force;
          end else if (r_cnt != C_MAX_TC) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s       = r_s;
  assign bus.gnt     = r_gnt;
  assign bus.busy    = r_busy;
  assign bus.expired = r_expired;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux_sel_arbiter
// Scoreboard bench: the stimulus process drives req/done on the falling edge,
// advances a cycle-level reference model of the arbitration rules and queues
// the outputs expected after the next rising edge. A separate monitor pops
// and compares shortly after each rising edge.
// ---------------------------------------------------------------------------
module tb_mux_sel_arbiter;

  localparam int HOLD = 4;
  localparam int MAX  = 16;

  typedef struct packed {
    logic [1:0] s;
    logic [3:0] gnt;
    logic       busy;
    logic       expired;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux_sel_arbiter_if bus();

  mux_sel_arbiter #(
    .HOLD_CYCLES (HOLD),
    .MAX_CYCLES  (MAX)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: owner = -1 when nobody holds the mux, age = number of
  // cycles the current owner has been visible on gnt.
  int m_owner;
  int m_age;
  int m_last;
  int m_s;
  bit m_exp;

  function automatic void model_reset();
    m_owner = -1;
    m_age   = 0;
    m_last  = 3;
    m_s     = 0;
    m_exp   = 1'b0;
  endfunction

  function automatic void model_step(input logic [3:0] rq, input logic dn);
    bit fin;
    bit frc;
    if (m_owner < 0) begin
      m_exp = 1'b0;
      for (int j = 1; j <= 4; j++) begin
        if (rq[(m_last + j) % 4]) begin
          m_owner = (m_last + j) % 4;
          m_s     = m_owner;
          m_age   = 1;
          break;
        end
      end
    end else begin
      fin = (m_age >= HOLD) && (dn || !rq[m_owner]);
      frc = !fin && (m_age >= MAX);
      if (fin || frc) begin
        m_last  = m_owner;
        m_owner = -1;
        m_exp   = frc;
      end else begin
        m_age++;
      end
    end
  endfunction

  function automatic obs_t model_out();
    obs_t o;
    o.s       = 2'(m_s);
    o.gnt     = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    o.busy    = (m_owner >= 0);
    o.expired = m_exp;
    return o;
  endfunction

  task automatic cyc(input logic rst, input logic [3:0] rq, input logic dn);
    @(negedge clk);
    rst_n    = rst;
    bus.req  = rq;
    bus.done = dn;
    if (!rst) model_reset();
    else      model_step(rq, dn);
    exp_q.push_back(model_out());
  endtask

  // Monitor
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        obs_t e;
        obs_t a;
        e = exp_q.pop_front();
        a = {bus.s, bus.gnt, bus.busy, bus.expired};
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL out t=%0t got s=%0d gnt=%b busy=%b exp=%b want s=%0d gnt=%b busy=%b exp=%b",
                   $time, a.s, a.gnt, a.busy, a.expired, e.s, e.gnt, e.busy, e.expired);
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic [3:0] rq;
    logic       dn;
    obs_t       a;
    bus.req  = 4'hF;
    bus.done = 1'b0;
    model_reset();

    // reset with all requesting, then round-robin with done held
    repeat (3) cyc(1'b0, 4'hF, 1'b0);
    repeat (26) cyc(1'b1, 4'hF, 1'b1);

    // single requester channel 2, done from the second cycle
    repeat (8) cyc(1'b1, 4'h0, 1'b0);
    cyc(1'b1, 4'b0100, 1'b0);
    cyc(1'b1, 4'b0100, 1'b0);
    repeat (12) cyc(1'b1, 4'b0100, 1'b1);

    // channel 1 never releases -> timeout and re-grant
    repeat (8) cyc(1'b1, 4'h0, 1'b0);
    repeat (40) cyc(1'b1, 4'b0010, 1'b0);

    // one-cycle request on channel 3
    repeat (8) cyc(1'b1, 4'h0, 1'b1);
    cyc(1'b1, 4'b1000, 1'b0);
    repeat (8) cyc(1'b1, 4'h0, 1'b0);

    // asynchronous reset in the middle of a channel 1 grant
    repeat (3) cyc(1'b1, 4'b0010, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    a = {bus.s, bus.gnt, bus.busy, bus.expired};
    n_cmp++;
    if (a !== 8'h00) begin
      n_bad++;
      $display("FAIL async_rst got s=%0d gnt=%b busy=%b exp=%b want s=0 gnt=0000 busy=0 exp=0",
               a.s, a.gnt, a.busy, a.expired);
    end
    repeat (2) cyc(1'b0, 4'b0010, 1'b0);
    repeat (6) cyc(1'b1, 4'b0010, 1'b1);

    // randomized phases with varying done probability and request churn
    rq = 4'h0;
    for (int p = 0; p < 12; p++) begin
      int dpct;
      int chg;
      case ($urandom_range(0, 2))
        0:       dpct = 0;
        1:       dpct = 30;
        default: dpct = 100;
      endcase
      chg = ($urandom_range(0, 1) == 1) ? 4 : 40;
      repeat (150) begin
        if ($urandom_range(1, chg) == 1) rq = 4'($urandom_range(0, 15));
        dn = (int'($urandom_range(0, 99)) < dpct);
        cyc(1'b1, rq, dn);
      end
    end

    // drain the scoreboard, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
